qu_decode: RTL

QU_DECODE -- requirements
Module: qu_decode

---
 rtl/qu_common_pkg.sv | 81 ++++++++
 rtl/qu_imm_gen.sv | 38 +++
 rtl/qu_decode.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/qu_common_pkg.sv
// Shared types and constants for the qu decode stage: raw/decoded instruction
// types, op classes, RV32I opcode and function-field encodings.
package qu_common;

  localparam int QU_PC_WIDTH = 12;

  typedef logic [31:0] instr_t;
  typedef logic [31:0] imm32_t;

  // OP_ILLEGAL is the all-zero encoding so a cleared dec_instr_t is self-consistent.
  typedef enum logic [3:0] {
    OP_ILLEGAL = 4'd0,
    OP_R,
    OP_I,
    OP_LOAD,
    OP_S,
    OP_B,
    OP_JAL,
    OP_JALR,
    OP_LUI,
    OP_AUIPC,
    OP_SYSTEM,
    OP_FENCE
  } dec_op_t;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_S      = 7'b0100011;
  localparam logic [6:0] OPC_B      = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_ADD     = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_PRIV    = 3'b000;
  localparam logic [2:0] F3_CSR_RSV = 3'b100;
  localparam logic [2:0] F3_S_MAX   = 3'b010;

  typedef struct packed {
    dec_op_t     op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    imm32_t      imm32;
    logic        rd_we;
    logic        rs1_used;
    logic        rs2_used;
    logic        illegal;
  } dec_instr_t;

  function automatic dec_op_t op_class(input logic [6:0] opc);
    dec_op_t op;
    unique case (opc)
      OPC_R:      op = OP_R;
      OPC_I:      op = OP_I;
      OPC_LOAD:   op = OP_LOAD;
      OPC_S:      op = OP_S;
      OPC_B:      op = OP_B;
      OPC_JAL:    op = OP_JAL;
      OPC_JALR:   op = OP_JALR;
      OPC_LUI:    op = OP_LUI;
      OPC_AUIPC:  op = OP_AUIPC;
      OPC_SYSTEM: op = OP_SYSTEM;
      OPC_FENCE:  op = OP_FENCE;
      default:    op = OP_ILLEGAL;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/qu_imm_gen.sv
// Combinational immediate extraction: picks the RV32I immediate format implied
// by the op class and sign-extends it (CSR address is zero-extended).
module qu_imm_gen
  import qu_common::*;
(
  input  instr_t  i_instr,
  input  dec_op_t i_op,
  output imm32_t  o_imm
);

  // Opcode bits are consumed by the op class, not by the immediate muxing.
  logic w_unused_opc;
  assign w_unused_opc = &{1'b0, i_instr[6:0]};

  always_comb begin
    // NOTE: default assignment first so every path drives o_imm and no latch is inferred.
    o_imm = '0;
    unique case (i_op)
      OP_I, OP_LOAD, OP_JALR, OP_FENCE:
        o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
      OP_S:
        o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      OP_B:
        o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                 i_instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        o_imm = {i_instr[31:12], 12'b0};
      OP_JAL:
        o_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                 i_instr[30:21], 1'b0};
      OP_SYSTEM:
        o_imm = {20'b0, i_instr[31:20]};
      default:
        o_imm = '0;
    endcase
  end

endmodule

// File: rtl/qu_decode.sv
// RV32I decode stage with a registered output slot plus one skid entry.
// Optional macro QU_DECODE_CSR_EN enables SYSTEM (ECALL/EBREAK/CSR) decoding.
module qu_decode
  import qu_common::*;
#(
  parameter int PC_WIDTH = QU_PC_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  instr_t              in_instr,
  input  logic [PC_WIDTH-1:0] in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output dec_instr_t          out_dec,
  output logic [PC_WIDTH-1:0] out_pc
);

  dec_op_t             w_op;
  imm32_t              w_imm;
  dec_instr_t          w_dec;
  logic [2:0]          w_f3;
  logic [6:0]          w_f7;
  logic                w_illegal;
  logic                w_writes_rd;
  logic                w_reads_rs1;
  logic                w_reads_rs2;

  logic                r_out_valid;
  logic                r_skid_valid;
  logic                r_in_ready;
  dec_instr_t          r_out_dec;
  logic [PC_WIDTH-1:0] r_out_pc;
  dec_instr_t          r_skid_dec;
  logic [PC_WIDTH-1:0] r_skid_pc;

  logic                w_in_fire;
  logic                w_out_fire;
  logic                w_out_free;
  logic                w_load_out;
  logic                w_load_skid;
  logic                w_out_valid_nxt;
  logic                w_skid_valid_nxt;

  assign w_op = op_class(in_instr[6:0]);
  assign w_f3 = in_instr[14:12];
  assign w_f7 = in_instr[31:25];

  qu_imm_gen u_imm_gen (
    .i_instr (in_instr),
    .i_op    (w_op),
    .o_imm   (w_imm)
  );

  always_comb begin
    w_illegal   = (in_instr[1:0] != 2'b11);
    w_writes_rd = 1'b0;
    w_reads_rs1 = 1'b0;
    w_reads_rs2 = 1'b0;
    unique case (w_op)
      OP_R: begin
        {w_writes_rd, w_reads_rs1, w_reads_rs2} = 3'b111;
        w_illegal = w_illegal | !(w_f7 == F7_BASE || w_f7 == F7_ALT)
                  | (w_f7 == F7_ALT && !(w_f3 == F3_ADD || w_f3 == F3_SR));
      end
      OP_I: begin
        {w_writes_rd, w_reads_rs1} = 2'b11;
        if (w_f3 == F3_SLL)
          w_illegal = w_illegal | (w_f7 != F7_BASE);
        else if (w_f3 == F3_SR)
          w_illegal = w_illegal | !(w_f7 == F7_BASE || w_f7 == F7_ALT);
      end
      OP_LOAD: begin
        {w_writes_rd, w_reads_rs1} = 2'b11;
        w_illegal = w_illegal | (w_f3 inside {3'b011, 3'b110, 3'b111});
      end
      OP_S: begin
        {w_reads_rs1, w_reads_rs2} = 2'b11;
        w_illegal = w_illegal | (w_f3 > F3_S_MAX);
      end
      OP_B: begin
        {w_reads_rs1, w_reads_rs2} = 2'b11;
        w_illegal = w_illegal | (w_f3 inside {3'b010, 3'b011});
      end
      OP_JALR: begin
        {w_writes_rd, w_reads_rs1} = 2'b11;
        w_illegal = w_illegal | (w_f3 != 3'b000);
      end
      OP_JAL, OP_LUI, OP_AUIPC: w_writes_rd = 1'b1;
      OP_FENCE: w_writes_rd = 1'b0;
      OP_SYSTEM: begin
`ifdef QU_DECODE_CSR_EN
        // Only exact ECALL/EBREAK encodings are accepted under funct3=000.
        if (w_f3 == F3_PRIV)
          w_illegal = w_illegal | (in_instr[11:7] != 5'd0) | (in_instr[19:15] != 5'd0)
                    | (in_instr[31:21] != 11'd0);
        else if (w_f3 == F3_CSR_RSV)
          w_illegal = 1'b1;
        else begin
          w_writes_rd = 1'b1;
          w_reads_rs1 = ~w_f3[2];
        end
`else
        w_illegal = 1'b1;
`endif
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // Illegal instructions pass through but claim no register reads or writes.
  always_comb begin
    w_dec          = '0;
    w_dec.op       = w_op;
    w_dec.funct3   = w_f3;
    w_dec.funct7   = w_f7;
    w_dec.rd       = in_instr[11:7];
    w_dec.rs1      = in_instr[19:15];
    w_dec.rs2      = in_instr[24:20];
    w_dec.imm32    = w_imm;
    w_dec.illegal  = w_illegal;
    w_dec.rd_we    = w_writes_rd & ~w_illegal & (in_instr[11:7] != 5'd0);
    w_dec.rs1_used = w_reads_rs1 & ~w_illegal;
    w_dec.rs2_used = w_reads_rs2 & ~w_illegal;
  end

  // in_ready is registered, so an accepted beat always finds the skid entry empty.
  assign w_in_fire   = in_valid & r_in_ready & ~flush;
  assign w_out_fire  = r_out_valid & out_ready;
  assign w_out_free  = ~r_out_valid | w_out_fire;
  assign w_load_out  = ~flush & w_out_free & (r_skid_valid | w_in_fire);
  assign w_load_skid = ~flush & ~w_out_free & w_in_fire;

  always_comb begin
    w_out_valid_nxt  = r_out_valid;
    w_skid_valid_nxt = r_skid_valid;
    if (flush) begin
      w_out_valid_nxt  = 1'b0;
      w_skid_valid_nxt = 1'b0;
    end else if (w_out_free) begin
      w_out_valid_nxt  = r_skid_valid | w_in_fire;
      w_skid_valid_nxt = 1'b0;
    end else if (w_in_fire) begin
      w_skid_valid_nxt = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b0;
      r_out_dec    <= '0;
      r_out_pc     <= '0;
    end else begin
      r_out_valid  <= w_out_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_in_ready   <= ~w_skid_valid_nxt;
      if (w_load_out) begin
        r_out_dec <= r_skid_valid ? r_skid_dec : w_dec;
        r_out_pc  <= r_skid_valid ? r_skid_pc  : in_pc;
      end
    end
  end

  // NOTE: skid payload has no reset; r_skid_valid alone qualifies it.
  always_ff @(posedge clk) begin
    if (w_load_skid) begin
      r_skid_dec <= w_dec;
      r_skid_pc  <= in_pc;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_dec   = r_out_dec;
  assign out_pc    = r_out_pc;

endmodule
